// File: rtl/fir_coeff_bank.sv
// Four-entry FIR coefficient bank with a multi-cycle write, modwait pacing and set_done signalling.
// Optional index-order checking with a sticky err flag is enabled by defining COEFF_ORDER_CHECK_EN.
module fir_coeff_bank #(
    parameter int COEFF_WIDTH  = 16,
    parameter int WRITE_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_coeff,
    input  logic [1:0]               coefficient_num,
    input  logic [COEFF_WIDTH-1:0]   fir_coefficient,
    output logic                     modwait,
    output logic [4*COEFF_WIDTH-1:0] coeff_bus,
    output logic [3:0]               bank_valid,
    output logic                     set_done,
    output logic                     err
);

    localparam logic [3:0] CNT_INIT = 4'(WRITE_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [1:0]                    hold_idx_q, hold_idx_d;
    logic [COEFF_WIDTH-1:0]        hold_val_q, hold_val_d;
    logic                          modwait_q, modwait_d;
    logic [3:0][COEFF_WIDTH-1:0]   coeff_q, coeff_d;
    logic [3:0]                    bank_valid_q, bank_valid_d;
    logic                          set_done_q, set_done_d;
    logic                          set_ok;
`ifdef COEFF_ORDER_CHECK_EN
    logic                          err_q, err_d;
    logic [1:0]                    exp_idx_q, exp_idx_d;
    logic                          seq_ok_q, seq_ok_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_idx_d   = hold_idx_q;
        hold_val_d   = hold_val_q;
        modwait_d    = modwait_q;
        coeff_d      = coeff_q;
        bank_valid_d = bank_valid_q;
        set_done_d   = 1'b0;
        set_ok       = 1'b0;
`ifdef COEFF_ORDER_CHECK_EN
        err_d        = err_q;
        exp_idx_d    = exp_idx_q;
        seq_ok_d     = seq_ok_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_coeff) begin
                    hold_idx_d = coefficient_num;
                    hold_val_d = fir_coefficient;
                    cnt_d      = CNT_INIT;
                    modwait_d  = 1'b1;
                    state_d    = BUSY;
`ifdef COEFF_ORDER_CHECK_EN
                    // Index 0 always restarts a set; any other out-of-order index poisons it.
                    if (coefficient_num == 2'd0) begin
                        err_d    = 1'b0;
                        seq_ok_d = 1'b1;
                    end else if (coefficient_num != exp_idx_q) begin
                        err_d    = 1'b1;
                        seq_ok_d = 1'b0;
                    end
                    exp_idx_d = coefficient_num + 2'd1;
`endif
                end
            end
            BUSY: begin
`ifdef COEFF_ORDER_CHECK_EN
                if (load_coeff) begin
                    err_d = 1'b1;
                end
`endif
                if (cnt_q == 4'd0) begin
                    coeff_d[hold_idx_q] = hold_val_q;
                    if (hold_idx_q == 2'd0) begin
                        bank_valid_d = 4'b0001;
                    end else begin
                        bank_valid_d[hold_idx_q] = 1'b1;
                    end
                    set_ok = (hold_idx_q == 2'd3) && (bank_valid_q[2:0] == 3'b111);
`ifdef COEFF_ORDER_CHECK_EN
                    set_ok = set_ok && seq_ok_q;
`endif
                    set_done_d = set_ok;
                    modwait_d  = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_idx_q   <= '0;
            hold_val_q   <= '0;
            modwait_q    <= 1'b0;
            coeff_q      <= '0;
            bank_valid_q <= '0;
            set_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_idx_q   <= hold_idx_d;
            hold_val_q   <= hold_val_d;
            modwait_q    <= modwait_d;
            coeff_q      <= coeff_d;
            bank_valid_q <= bank_valid_d;
            set_done_q   <= set_done_d;
        end
    end

`ifdef COEFF_ORDER_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q     <= 1'b0;
            exp_idx_q <= 2'd0;
            seq_ok_q  <= 1'b1;
        end else begin
            err_q     <= err_d;
            exp_idx_q <= exp_idx_d;
            seq_ok_q  <= seq_ok_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign modwait    = modwait_q;
    assign coeff_bus  = coeff_q;
    assign bank_valid = bank_valid_q;
    assign set_done   = set_done_q;

endmodule

// File: tb/tb_fir_coeff_bank.sv
// Directed self-checking bench for fir_coeff_bank (WRITE_CYCLES=3, 16-bit coefficients).
// The order-check scenario only runs when COEFF_ORDER_CHECK_EN is defined.
module tb_fir_coeff_bank;

    localparam int WC = 3;
`ifdef COEFF_ORDER_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        load_coeff;
    logic [1:0]  coefficient_num;
    logic [15:0] fir_coefficient;
    logic        modwait;
    logic [63:0] coeff_bus;
    logic [3:0]  bank_valid;
    logic        set_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    fir_coeff_bank #(.COEFF_WIDTH(16), .WRITE_CYCLES(WC)) dut (
        .clk             (clk),
        .reset           (reset),
        .load_coeff      (load_coeff),
        .coefficient_num (coefficient_num),
        .fir_coefficient (fir_coefficient),
        .modwait         (modwait),
        .coeff_bus       (coeff_bus),
        .bank_valid      (bank_valid),
        .set_done        (set_done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One loader-timed write; optionally pulses a stray load (idx1, BEEF) in busy cycle 'intrude'.
    task automatic do_write(input string tag, input logic [1:0] idx, input logic [15:0] val,
                            input logic exp_sd, input int intrude);
        int n;
        @(negedge clk);
        load_coeff      = 1'b1;
        coefficient_num = idx;
        fir_coefficient = val;
        @(negedge clk);
        load_coeff = 1'b0;
        n = 0;
        while (modwait === 1'b1 && n < 20) begin
            n++;
            if (n == intrude) begin
                load_coeff      = 1'b1;
                coefficient_num = 2'd1;
                fir_coefficient = 16'hBEEF;
            end
            @(negedge clk);
            load_coeff = 1'b0;
        end
        check({tag, " modwait_len"}, 64'(n), 64'(WC));
        check({tag, " set_done"}, 64'(set_done), 64'(exp_sd));
        @(negedge clk);
        check({tag, " modwait_after"}, 64'(modwait), 64'd0);
        check({tag, " set_done_after"}, 64'(set_done), 64'd0);
    endtask

    initial begin
        reset           = 1'b1;
        load_coeff      = 1'b0;
        coefficient_num = 2'd0;
        fir_coefficient = 16'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset modwait", 64'(modwait), 64'd0);
        check("reset coeff_bus", coeff_bus, 64'd0);
        check("reset bank_valid", 64'(bank_valid), 64'd0);
        check("reset set_done", 64'(set_done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted mid-clock during the second busy cycle of an idx2 write.
        @(negedge clk);
        load_coeff      = 1'b1;
        coefficient_num = 2'd2;
        fir_coefficient = 16'hAAAA;
        @(negedge clk);
        load_coeff = 1'b0;
        check("midreset busy", 64'(modwait), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset modwait", 64'(modwait), 64'd0);
        check("midreset coeff_bus", coeff_bus, 64'd0);
        check("midreset bank_valid", 64'(bank_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("postreset modwait", 64'(modwait), 64'd0);
        check("postreset c2", coeff_bus, 64'd0);

        // Full clean set 0..3.
        do_write("set0", 2'd0, 16'h1111, 1'b0, 0);
        check("set0 bank_valid", 64'(bank_valid), 64'h1);
        do_write("set1", 2'd1, 16'h2222, 1'b0, 0);
        do_write("set2", 2'd2, 16'h3333, 1'b0, 0);
        check("set2 bank_valid", 64'(bank_valid), 64'h7);
        do_write("set3", 2'd3, 16'h4444, 1'b1, 0);
        check("set coeff_bus", coeff_bus, 64'h4444_3333_2222_1111);
        check("set bank_valid", 64'(bank_valid), 64'hF);
        check("set err", 64'(err), 64'd0);

        // New set begins: only bank_valid restarts, other entries retained.
        do_write("new0", 2'd0, 16'h5555, 1'b0, 0);
        check("new0 bank_valid", 64'(bank_valid), 64'h1);
        check("new0 coeff_bus", coeff_bus, 64'h4444_3333_2222_5555);

        // Stray load in first busy cycle, then in the cycle modwait falls; both ignored.
        do_write("busyld", 2'd0, 16'h6666, 1'b0, 1);
        check("busyld coeff_bus", coeff_bus, 64'h4444_3333_2222_6666);
        check("busyld bank_valid", 64'(bank_valid), 64'h1);
        check("busyld err", 64'(err), 64'(ERR_ON));
        do_write("fallld", 2'd2, 16'h7777, 1'b0, WC);
        check("fallld coeff_bus", coeff_bus, 64'h4444_7777_2222_6666);
        check("fallld bank_valid", 64'(bank_valid), 64'h5);

        // Same index twice: last write wins, bank_valid unchanged.
        do_write("dup", 2'd2, 16'h8888, 1'b0, 0);
        check("dup coeff_bus", coeff_bus, 64'h4444_8888_2222_6666);
        check("dup bank_valid", 64'(bank_valid), 64'h5);

`ifdef COEFF_ORDER_CHECK_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_write("ord0", 2'd0, 16'h0001, 1'b0, 0);
        check("ord0 err", 64'(err), 64'd0);
        do_write("ord2", 2'd2, 16'h0003, 1'b0, 0);
        check("ord2 err", 64'(err), 64'd1);
        do_write("ord1", 2'd1, 16'h0002, 1'b0, 0);
        do_write("ord3", 2'd3, 16'h0004, 1'b0, 0);
        check("ord3 err", 64'(err), 64'd1);
        do_write("clean0", 2'd0, 16'h0011, 1'b0, 0);
        check("clean0 err", 64'(err), 64'd0);
        do_write("clean1", 2'd1, 16'h0022, 1'b0, 0);
        do_write("clean2", 2'd2, 16'h0033, 1'b0, 0);
        do_write("clean3", 2'd3, 16'h0044, 1'b1, 0);
        check("clean err", 64'(err), 64'd0);
        check("clean coeff_bus", coeff_bus, 64'h0044_0033_0022_0011);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
